// File: rtl/mac_dot_sequencer_pkg.sv
// rtl/mac_dot_sequencer_pkg.sv - shared widths, limits and state type for the dot-product sequencer
package mac_dot_sequencer_pkg;

    localparam int DATA_W  = 14;
    localparam int ACC_W   = 28;
    localparam int ADDR_W  = 8;
    localparam int LEN_W   = ADDR_W + 1;
    localparam int MAC_LAT = 6;
    localparam int WDOG    = 16;

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(2 ** ADDR_W);
    localparam logic [7:0]       WD_LIMIT = 8'(MAC_LAT + WDOG);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } seq_state_t;

    // Requests longer than the memory can hold are cut to the full address range.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// rtl/mac_dot_sequencer_if.sv - memory, MAC and result signals seen by the sequencer
interface mac_dot_sequencer_if;
    import mac_dot_sequencer_pkg::*;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] x_data;
    logic [DATA_W-1:0] w_data;
    logic              mac_reset;
    logic              mac_valid_in;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [ACC_W-1:0]  mac_f;
    logic              mac_valid_out;
    logic [ACC_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mem_rd_en, mem_addr, mac_reset, mac_valid_in, mac_a, mac_b,
        output out_data, out_valid,
        input  x_data, w_data, mac_f, mac_valid_out, out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, mac_reset, mac_valid_in, mac_a, mac_b,
        input  out_data, out_valid,
        output x_data, w_data, mac_f, mac_valid_out, out_ready
    );

endinterface

// File: rtl/mac_dot_sequencer.sv
// rtl/mac_dot_sequencer.sv - drives a pipelined MAC through one dot product and returns the sum
module mac_dot_sequencer
    import mac_dot_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic               busy_o,
    output logic               err_o,
    mac_dot_sequencer_if.master bus
);

    seq_state_t        state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issue_q;
    logic [LEN_W-1:0]  ret_q;
    logic [LEN_W-1:0]  ret_d;
    logic [7:0]        wd_q;
    logic              busy_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic              vin_q;
    logic [ACC_W-1:0]  out_data_q;
    logic              out_valid_q;
    logic              err_q;

    assign ret_d = ret_q + LEN_W'(1);

    // Sequencer FSM with issue, return and watchdog counters and the result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issue_q     <= '0;
            ret_q       <= '0;
            wd_q        <= '0;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            vin_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Memory data arrives one cycle after the read, so the MAC strobe trails by one.
            vin_q <= rd_en_q;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        len_q   <= clamp_len(len_i);
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    ret_q   <= '0;
                    wd_q    <= '0;
                    issue_q <= LEN_W'(1);
                    if (len_q == '0) begin
                        out_data_q  <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        rd_en_q <= 1'b1;
                        addr_q  <= '0;
                        state_q <= FEED;
                    end
                end
                FEED, DRAIN: begin
                    if (state_q == FEED) begin
                        if (issue_q == len_q) begin
                            rd_en_q <= 1'b0;
                            state_q <= DRAIN;
                        end else begin
                            addr_q  <= issue_q[ADDR_W-1:0];
                            issue_q <= issue_q + LEN_W'(1);
                        end
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
                    // A returning result takes priority over the watchdog on the same edge.
                    if (bus.mac_valid_out) begin
                        ret_q <= ret_d;
                        if (ret_d == len_q) begin
                            out_data_q  <= bus.mac_f;
                            out_valid_q <= 1'b1;
                            rd_en_q     <= 1'b0;
                            state_q     <= DONE;
                        end
                    end else if (state_q == DRAIN && wd_q > WD_LIMIT) begin
                        err_q       <= 1'b1;
                        out_data_q  <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign err_o            = err_q;
    assign bus.mem_rd_en    = rd_en_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mac_valid_in = vin_q;
    assign bus.mac_reset    = reset | (state_q == CLEAR);
    assign bus.mac_a        = bus.x_data;
    assign bus.mac_b        = bus.w_data;
    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;

endmodule
